// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX-operand forwarding select for one source register; MEM result is newer than WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_reg_wr,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_reg_wr,
  output logic [1:0]       o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (i_mem_reg_wr && (i_mem_rd != '0) && (i_mem_rd == i_src))
      o_sel = FWD_MEM;
    else if (i_wb_reg_wr && (i_wb_rd != '0) && (i_wb_rd == i_src))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, forwarding selects, load-use bubbles,
// branch flushes and data-memory freezes with saturating event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic [REG_W-1:0] i_ex_rs,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_tk,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_mem_reg_wr,
  input  logic             i_wb_reg_wr,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_memwb_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_lu_cnt,
  output logic [CNT_W-1:0] o_mw_cnt,
  output logic [CNT_W-1:0] o_fl_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_lu_cnt, r_mw_cnt, r_fl_cnt;

  logic w_frozen, w_lu_hit, w_branch, w_lu;

  // In MEM_WAIT the freeze holds until ack regardless of dmem_req.
  assign w_frozen = !i_dmem_ack && ((r_state == MEM_WAIT) || i_dmem_req);
  assign w_lu_hit = i_ex_mem_read && (i_ex_rd != '0) &&
                    ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
  assign w_branch = i_ex_branch_tk && !w_frozen;
  assign w_lu     = w_lu_hit && !i_ex_branch_tk && !w_frozen;

  assign o_pc_en       = !w_frozen && !w_lu;
  assign o_ifid_en     = !w_frozen && !w_lu;
  assign o_idex_en     = !w_frozen;
  assign o_exmem_en    = !w_frozen;
  assign o_memwb_en    = 1'b1;
  assign o_ifid_flush  = w_branch;
  assign o_idex_flush  = w_branch || w_lu;
  assign o_memwb_flush = w_frozen;

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .i_src(i_ex_rs), .i_mem_rd(i_mem_rd), .i_mem_reg_wr(i_mem_reg_wr),
    .i_wb_rd(i_wb_rd), .i_wb_reg_wr(i_wb_reg_wr), .o_sel(o_fwd_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .i_src(i_ex_rt), .i_mem_rd(i_mem_rd), .i_mem_reg_wr(i_mem_reg_wr),
    .i_wb_rd(i_wb_rd), .i_wb_reg_wr(i_wb_reg_wr), .o_sel(o_fwd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
      r_lu_cnt   <= '0;
      r_mw_cnt   <= '0;
      r_fl_cnt   <= '0;
    end else begin
      if (r_state == RUN) begin
        if (i_dmem_req && !i_dmem_ack) begin
          r_state    <= MEM_WAIT;
          r_wait_cnt <= '0;
        end
      end else begin
        if (i_dmem_ack) begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end else begin
          if (r_wait_cnt != WC_MAX) r_wait_cnt <= r_wait_cnt + WC_W'(1);
          if (r_wait_cnt == WC_LAST) r_mem_err <= 1'b1;
        end
      end
      if (w_lu && (r_lu_cnt != '1))     r_lu_cnt <= r_lu_cnt + CNT_W'(1);
      if (w_frozen && (r_mw_cnt != '1)) r_mw_cnt <= r_mw_cnt + CNT_W'(1);
      if (w_branch && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + CNT_W'(1);
    end
  end

  assign o_mem_err = r_mem_err;
  assign o_lu_cnt  = r_lu_cnt;
  assign o_mw_cnt  = r_mw_cnt;
  assign o_fl_cnt  = r_fl_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int MT    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // control vector order: pc, ifid, idex, exmem, memwb enables, ifid/idex/memwb flushes
  localparam logic [7:0] C_IDLE   = 8'b11111_000;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_BR     = 8'b11111_110;
  localparam logic [7:0] C_FRZ    = 8'b00000_001;
  localparam logic [7:0] M_FRZ    = 8'b11110_111; // memwb_en is don't-care while frozen

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rt, ex_mem_read, ex_branch_tk, mem_reg_wr, wb_reg_wr, dmem_req, dmem_ack;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic mem_err;
  logic [CNT_W-1:0] lu_cnt, mw_cnt, fl_cnt;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rd(ex_rd),
    .i_ex_mem_read(ex_mem_read), .i_ex_branch_tk(ex_branch_tk),
    .i_mem_rd(mem_rd), .i_wb_rd(wb_rd), .i_mem_reg_wr(mem_reg_wr), .i_wb_reg_wr(wb_reg_wr),
    .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
    .o_memwb_en(memwb_en), .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
    .o_memwb_flush(memwb_flush), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_mem_err(mem_err),
    .o_lu_cnt(lu_cnt), .o_mw_cnt(mw_cnt), .o_fl_cnt(fl_cnt)
  );

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ex_mem_read = 0; ex_branch_tk = 0; mem_rd = '0; wb_rd = '0;
    mem_reg_wr = 0; wb_reg_wr = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Leaves time just after an async reset pulse, before the next falling edge.
  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_IDLE); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b exp 0000", {fwd_a, fwd_b}); end
    checks++; if ({mem_err, lu_cnt, mw_cnt, fl_cnt} !== '0) begin errors++;
      $display("FAIL reset_state err=%b lu=%0d mw=%0d fl=%0d exp all 0", mem_err, lu_cnt, mw_cnt, fl_cnt); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5;
    @(negedge clk);
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs_ctl got %b exp %b", ctl, C_LU); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (lu_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt1 got %0d exp 1", lu_cnt); end
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_release got %b exp %b", ctl, C_IDLE); end
    next_cycle();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    @(negedge clk);
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_r0 got %b exp %b", ctl, C_IDLE); end
    next_cycle();
    ex_rd = 7; id_rt = 7; id_rs = 1; id_uses_rt = 0;
    @(negedge clk);
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_rt_unused got %b exp %b", ctl, C_IDLE); end
    next_cycle();
    id_uses_rt = 1;
    @(negedge clk);
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rt_used got %b exp %b", ctl, C_LU); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (lu_cnt !== 4'd2) begin errors++; $display("FAIL lu_cnt2 got %0d exp 2", lu_cnt); end
    next_cycle();
  endtask

  task automatic test_forwarding();
    do_reset();
    mem_rd = 3; wb_rd = 3; ex_rs = 3; ex_rt = 3; mem_reg_wr = 1; wb_reg_wr = 1;
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin errors++; $display("FAIL fwd_mem got %b exp 1010", {fwd_a, fwd_b}); end
    next_cycle();
    mem_reg_wr = 0;
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_wb got %b exp 0101", {fwd_a, fwd_b}); end
    next_cycle();
    mem_reg_wr = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL fwd_r0 got %b exp 0000", {fwd_a, fwd_b}); end
    next_cycle();
  endtask

  task automatic test_mem_freeze();
    do_reset();
    dmem_req = 1; dmem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ((ctl & M_FRZ) !== C_FRZ) begin errors++; $display("FAIL freeze_%0d got %b exp %b", i, ctl, C_FRZ); end
      next_cycle();
    end
    dmem_ack = 1;
    @(negedge clk);
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL freeze_release got %b exp %b", ctl, C_IDLE); end
    next_cycle();
    dmem_req = 0; dmem_ack = 0;
    @(negedge clk);
    checks++; if (mw_cnt !== 4'd3) begin errors++; $display("FAIL mw_cnt got %0d exp 3", mw_cnt); end
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL freeze_back_run got %b exp %b", ctl, C_IDLE); end
    next_cycle();
    dmem_req = 1; dmem_ack = 1;
    @(negedge clk);
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL req_ack_same got %b exp %b", ctl, C_IDLE); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_tk = 1; ex_mem_read = 1; ex_rd = 4; id_rs = 4;
    @(negedge clk);
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_lu got %b exp %b", ctl, C_BR); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if ({lu_cnt, fl_cnt} !== {4'd0, 4'd1}) begin errors++;
      $display("FAIL br_cnts got lu=%0d fl=%0d exp lu=0 fl=1", lu_cnt, fl_cnt); end
    next_cycle();
    ex_branch_tk = 1; dmem_req = 1;
    @(negedge clk);
    checks++; if ((ctl & M_FRZ) !== C_FRZ) begin errors++; $display("FAIL br_frozen got %b exp %b", ctl, C_FRZ); end
    next_cycle();
    dmem_ack = 1;
    @(negedge clk);
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_release got %b exp %b", ctl, C_BR); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (fl_cnt !== 4'd2) begin errors++; $display("FAIL br_fl_cnt got %0d exp 2", fl_cnt); end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1;
    next_cycle(); // entry cycle in RUN
    for (int w = 1; w <= MT + 1; w++) begin
      @(negedge clk);
      // mem_err reflects wait cycles completed before this one
      checks++; if (mem_err !== ((w - 1) >= MT)) begin errors++;
        $display("FAIL timeout_err_w%0d got %b exp %b", w, mem_err, ((w - 1) >= MT)); end
      checks++; if ((ctl & M_FRZ) !== C_FRZ) begin errors++; $display("FAIL timeout_frz_w%0d got %b exp %b", w, ctl, C_FRZ); end
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    checks++; if ({ctl, mem_err, mw_cnt} !== {C_IDLE, 1'b0, 4'd0}) begin errors++;
      $display("FAIL timeout_rst got ctl=%b err=%b mw=%0d exp ctl=%b err=0 mw=0", ctl, mem_err, mw_cnt, C_IDLE); end
    next_cycle();
  endtask

  task automatic test_random();
    bit m_wait, m_err, frz, br, lu;
    int m_wc, m_lu, m_mw, m_fl;
    logic [1:0] ea, eb;
    logic [7:0] ec, mask;
    do_reset();
    m_wait = 0; m_err = 0; m_wc = 0; m_lu = 0; m_mw = 0; m_fl = 0;
    for (int n = 0; n < 400; n++) begin
      id_rs = REG_W'($urandom_range(0, 3)); id_rt = REG_W'($urandom_range(0, 3));
      ex_rs = REG_W'($urandom_range(0, 3)); ex_rt = REG_W'($urandom_range(0, 3));
      ex_rd = REG_W'($urandom_range(0, 3)); mem_rd = REG_W'($urandom_range(0, 3));
      wb_rd = REG_W'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); ex_mem_read = 1'($urandom); mem_reg_wr = 1'($urandom);
      wb_reg_wr = 1'($urandom); ex_branch_tk = ($urandom_range(0, 3) == 0);
      dmem_req = ($urandom_range(0, 4) == 0); dmem_ack = ($urandom_range(0, 2) == 0);
      frz = !dmem_ack && (m_wait || dmem_req);
      br  = ex_branch_tk && !frz;
      lu  = !frz && !ex_branch_tk && ex_mem_read && ex_rd != 0 &&
            (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
      ea = (mem_reg_wr && mem_rd != 0 && mem_rd == ex_rs) ? 2'b10 :
           (wb_reg_wr && wb_rd != 0 && wb_rd == ex_rs) ? 2'b01 : 2'b00;
      eb = (mem_reg_wr && mem_rd != 0 && mem_rd == ex_rt) ? 2'b10 :
           (wb_reg_wr && wb_rd != 0 && wb_rd == ex_rt) ? 2'b01 : 2'b00;
      ec   = frz ? C_FRZ : br ? C_BR : lu ? C_LU : C_IDLE;
      mask = frz ? M_FRZ : 8'hFF;
      @(negedge clk);
      checks++; if ((ctl & mask) !== ec) begin errors++; $display("FAIL rnd_ctl n=%0d got %b exp %b", n, ctl, ec); end
      checks++; if ({fwd_a, fwd_b} !== {ea, eb}) begin errors++; $display("FAIL rnd_fwd n=%0d got %b exp %b", n, {fwd_a, fwd_b}, {ea, eb}); end
      checks++; if ({mem_err, lu_cnt, mw_cnt, fl_cnt} !== {m_err, CNT_W'(m_lu), CNT_W'(m_mw), CNT_W'(m_fl)}) begin errors++;
        $display("FAIL rnd_state n=%0d got err=%b lu=%0d mw=%0d fl=%0d exp err=%b lu=%0d mw=%0d fl=%0d",
                 n, mem_err, lu_cnt, mw_cnt, fl_cnt, m_err, m_lu, m_mw, m_fl); end
      next_cycle();
      if (lu && m_lu < CMAX) m_lu++;
      if (br && m_fl < CMAX) m_fl++;
      if (frz && m_mw < CMAX) m_mw++;
      if (m_wait) begin
        if (dmem_ack) m_wait = 0;
        else begin m_wc++; if (m_wc >= MT) m_err = 1; end
      end else if (dmem_req && !dmem_ack) begin
        m_wait = 1; m_wc = 0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #12 rst = 1'b0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_freeze();
    test_branch();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
